sid_wave_mix: RTL and testbench
===============================

// Module: sid_wave_mix
// PURPOSE
//  Time-multiplexed N-voice SID waveform generator and mixer; next generation of the single-voice wave stage.
//  One start request snapshots every voice's accumulator, LFSR, pulse width, control and volume.
//  It then evaluates one voice per cycle through a 3-stage pipeline (wave, volume scale, accumulate).
//  It presents one mixed sample on a valid/ready output. Sits between the per-voice oscillators and the filter/DAC.
// PARAMETERS
//  VOICES  3   number of voices (>=2); SLOT_W = $clog2(VOICES)
//  ACC_W   24  phase accumulator width per voice
//  LFSR_W  23  noise LFSR width per voice (>=21)
//  WAVE_W  12  waveform/mix sample width (8..ACC_W-1)
//  VOL_W   8   per-voice volume width
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 synchronous reset, active high
//  start      in   1                 request a frame; accepted only when start_ready=1
//  start_ready out 1                 1 in IDLE
//  acc        in   VOICES*ACC_W      voice i at [i*ACC_W +: ACC_W]
//  lfsr       in   VOICES*LFSR_W     voice i at [i*LFSR_W +: LFSR_W]
//  pw         in   VOICES*WAVE_W     pulse width per voice
//  ctrl       in   VOICES*5          per voice {ring,triangle,saw,pulse,noise}
//  vol        in   VOICES*VOL_W      per-voice volume
//  mix        out  WAVE_W            mixed sample
//  mix_valid  out  1                 mix holds a new sample
//  mix_ready  in   1                 consumer accepts mix
// BEHAVIOUR
//  Clock/reset: one clock, clk; reset rst is synchronous and active-high.
//  Reset: state=IDLE, start_ready=1, mix=0, mix_valid=0, pipeline valids=0, accumulator=0.
//  Reset mid-frame aborts the frame; no sample is produced.
//  FSM:
//   IDLE  -> RUN on start.
//   RUN   issues slots 0..VOICES-1, one per cycle -> DRAIN after slot VOICES-1.
//   DRAIN waits for the accumulate stage to finish -> HOLD.
//   HOLD  -> IDLE on mix_valid && mix_ready.
//  start outside IDLE is ignored; no queuing.
//  Snapshot: all voice inputs are registered on the accepting edge. Input changes mid-frame have no effect.
//  Per-voice wave (stage 1), using snapshot values:
//   top    = acc[ACC_W-1 -: WAVE_W]
//   saw    = top
//   pulse  = (top < pw) ? all-ones : 0   (unsigned compare)
//   tri    = {acc[ACC_W-2 -: WAVE_W-1], 1'b0}; inverted if acc[ACC_W-1] XOR (ring && ring_in)
//   noise  = {lfsr[20],[18],[14],[11],[9],[5],[2],[0], (WAVE_W-8) zeros}
//   wave   = all-ones ANDed with every enabled waveform; no waveform enabled -> all-ones.
//  ring_in of voice i = snapshot acc MSB of voice (i+VOICES-1)%VOICES (voice 0 takes voice VOICES-1).
//  Stage 2: scaled = (wave*vol) >> VOL_W; full-width product, result WAVE_W bits, unsigned, never overflows.
//  Stage 3: sum += scaled; sum is WAVE_W+SLOT_W bits, cleared on frame accept, cannot wrap.
//  Latency: mix/mix_valid are registered VOICES+3 edges after the accepting edge (6 for VOICES=3).
//  mix is stable while mix_valid=1 and mix_ready=0.
//  mix_valid drops on the handshake edge; mix keeps its last value.
// CONFIGURATION
//  SID_WAVE_MIX_SAT_EN undefined: mix = sum >> SLOT_W (attenuated, never clips).
//  SID_WAVE_MIX_SAT_EN defined:   mix = min(sum, 2^WAVE_W-1) (unity gain, hard clip).
// TESTING (defaults, VOICES=3; unused voices ctrl=0, vol=0 -> contribute 0)
//  T1 Reset: rst for 2 cycles.
//     -> mix=0, mix_valid=0, start_ready=1.
//     Then start with any inputs -> mix_valid 6 cycles later.
//  T2 Saw: v0 saw, acc=24'h800000, vol=8'hFF.
//     -> scaled 2040; mix=510 (no SAT) or 2040 (SAT).
//  T3 Pulse: v0 pulse, pw=12'h800, vol=8'h80.
//     acc=24'h7FF000 -> scaled 2047 (mix 511 / 2047).
//     acc=24'h800000 -> mix 0.
//  T4 Ring: v0 triangle+ring, acc0=24'h400000, acc2=24'h800000, vol0=8'hFF.
//     -> tri 0x7FF, scaled 2039, mix 509 / 2039.
//     Same with ring=0 -> tri 0x800, scaled 2040.
//  T5 Clip: all voices saw, acc=24'hFFF000, vol=8'hFF.
//     -> each 4079, sum 12237; mix 3059 (no SAT) or 4095 (SAT).
//  T6 Control: hold mix_ready=0 10 cycles.
//     -> mix stable, mix_valid=1, start ignored; then ready -> IDLE next cycle.
//     rst at cycle 3 of a frame -> no mix_valid, next frame correct.

Source files
------------

// File: rtl/sid_wave_mix.sv
// sid_wave_mix: time-multiplexed N-voice SID waveform generator and mixer.
// A start request snapshots every voice, then one voice per cycle flows
// through wave -> volume scale -> accumulate, and the mixed sample is
// presented on a valid/ready output.
// Build option: define SID_WAVE_MIX_SAT_EN for unity-gain hard-clipped mix;
// undefined gives an attenuated mix (sum >> SLOT_W) that never clips.

// Combinational wave stage for one voice.
module sid_wave_voice #(
  parameter int ACC_W  = 24,
  parameter int LFSR_W = 23,
  parameter int WAVE_W = 12
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [LFSR_W-1:0] lfsr,
  input  logic [WAVE_W-1:0] pw,
  input  logic [4:0]        ctrl,     // {ring,triangle,saw,pulse,noise}
  input  logic              ring_in,
  output logic [WAVE_W-1:0] wave
);
  logic [WAVE_W-1:0] top, pulse, tri_w, noise;

  // Build each waveform and AND together the enabled ones
  always_comb begin
    top   = acc[ACC_W-1 -: WAVE_W];
    pulse = (top < pw) ? '1 : '0;
    tri_w = {acc[ACC_W-2 -: WAVE_W-1], 1'b0};
    if (acc[ACC_W-1] ^ (ctrl[4] & ring_in)) tri_w = ~tri_w;
    noise = '0;
    noise[WAVE_W-1 -: 8] = {lfsr[20], lfsr[18], lfsr[14], lfsr[11],
                            lfsr[9], lfsr[5], lfsr[2], lfsr[0]};
    wave = '1;
    if (ctrl[3]) wave = wave & tri_w;
    if (ctrl[2]) wave = wave & top;
    if (ctrl[1]) wave = wave & pulse;
    if (ctrl[0]) wave = wave & noise;
  end
endmodule

module sid_wave_mix #(
  parameter int VOICES = 3,
  parameter int ACC_W  = 24,
  parameter int LFSR_W = 23,
  parameter int WAVE_W = 12,
  parameter int VOL_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     start_ready,
  input  logic [VOICES*ACC_W-1:0]  acc,
  input  logic [VOICES*LFSR_W-1:0] lfsr,
  input  logic [VOICES*WAVE_W-1:0] pw,
  input  logic [VOICES*5-1:0]      ctrl,
  input  logic [VOICES*VOL_W-1:0]  vol,
  output logic [WAVE_W-1:0]        mix,
  output logic                     mix_valid,
  input  logic                     mix_ready
);
  localparam int SLOT_W = $clog2(VOICES);
  localparam int SUM_W  = WAVE_W + SLOT_W;
  localparam int STAGES = 3;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  // Per-frame snapshot of every voice
  typedef struct packed {
    logic [VOICES-1:0][ACC_W-1:0]  acc;
    logic [VOICES-1:0][LFSR_W-1:0] lfsr;
    logic [VOICES-1:0][WAVE_W-1:0] pw;
    logic [VOICES-1:0][4:0]        ctrl;
    logic [VOICES-1:0][VOL_W-1:0]  vol;
  } frame_t;

  state_t                    state;
  frame_t                    snap;
  logic [SLOT_W-1:0]         slot, ring_slot;
  logic                      issue;
  logic [STAGES:1]           vld_pipe;
  logic [WAVE_W-1:0]         wave, s1_wave, s2_scaled;
  logic [VOL_W-1:0]          s1_vol;
  logic                      s1_last, s2_last;
  logic [WAVE_W+VOL_W-1:0]   prod;
  logic [SUM_W-1:0]          sum;
  logic [WAVE_W-1:0]         mix_next;

  assign issue     = (state == RUN);
  // Voice 0 takes its ring source from the highest voice
  assign ring_slot = (slot == '0) ? LAST : slot - 1'b1;
  assign prod      = {{VOL_W{1'b0}}, s1_wave} * {{WAVE_W{1'b0}}, s1_vol};

  sid_wave_voice #(.ACC_W(ACC_W), .LFSR_W(LFSR_W), .WAVE_W(WAVE_W)) u_voice (
    .acc     (snap.acc[slot]),
    .lfsr    (snap.lfsr[slot]),
    .pw      (snap.pw[slot]),
    .ctrl    (snap.ctrl[slot]),
    .ring_in (snap.acc[ring_slot][ACC_W-1]),
    .wave    (wave)
  );

  // Final output scaling of the accumulated sum
  always_comb begin
`ifdef SID_WAVE_MIX_SAT_EN
    mix_next = (sum > SUM_W'({WAVE_W{1'b1}})) ? '1 : sum[WAVE_W-1:0];
`else
    mix_next = sum[SUM_W-1:SLOT_W];
`endif
  end

  // Wave and volume-scale pipeline registers with valid shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_wave   <= '0;
      s1_vol    <= '0;
      s1_last   <= 1'b0;
      s2_scaled <= '0;
      s2_last   <= 1'b0;
    end else begin
      vld_pipe[1] <= issue;
      s1_wave     <= wave;
      s1_vol      <= snap.vol[slot];
      s1_last     <= (slot == LAST);
      vld_pipe[2] <= vld_pipe[1];
      s2_scaled   <= prod[WAVE_W+VOL_W-1:VOL_W];
      s2_last     <= s1_last;
      // Stage 3 flag: the last voice of the frame has been accumulated
      vld_pipe[3] <= vld_pipe[2] & s2_last;
    end
  end

  // Frame control FSM, snapshot, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      snap        <= '0;
      slot        <= '0;
      sum         <= '0;
      mix         <= '0;
      mix_valid   <= 1'b0;
    end else begin
      if (vld_pipe[2]) sum <= sum + SUM_W'(s2_scaled);
      case (state)
        IDLE: if (start) begin
          snap.acc    <= acc;
          snap.lfsr   <= lfsr;
          snap.pw     <= pw;
          snap.ctrl   <= ctrl;
          snap.vol    <= vol;
          slot        <= '0;
          sum         <= '0;
          start_ready <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          slot <= slot + 1'b1;
          if (slot == LAST) state <= DRAIN;
        end
        DRAIN: if (vld_pipe[3]) begin
          mix       <= mix_next;
          mix_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (mix_ready) begin
          mix_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sid_wave_mix.sv
// Directed-vector bench for sid_wave_mix (VOICES=3 defaults) with a
// scoreboard queue filled at frame accept and drained by a monitor.
module tb_sid_wave_mix;
  localparam int V = 3;
`ifdef SID_WAVE_MIX_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, start_ready, mix_valid, mix_ready;
  logic [V*24-1:0] acc;
  logic [V*23-1:0] lfsr;
  logic [V*12-1:0] pw;
  logic [V*5-1:0]  ctrl;
  logic [V*8-1:0]  vol;
  logic [11:0]     mix;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  sid_wave_mix dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .acc(acc), .lfsr(lfsr), .pw(pw), .ctrl(ctrl), .vol(vol),
    .mix(mix), .mix_valid(mix_valid), .mix_ready(mix_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && mix_valid && mix_ready) begin
      if (exp_q.size() == 0) check("unexpected sample", 1, 0);
      else check("mix", int'(mix), int'(exp_q.pop_front()));
    end
  end

  task automatic clear_inputs();
    acc = '0; lfsr = '0; pw = '0; ctrl = '0; vol = '0;
  endtask

  task automatic set_voice(input int i, input logic [23:0] a, input logic [22:0] l,
                           input logic [11:0] p, input logic [4:0] c, input logic [7:0] v);
    acc[i*24 +: 24] = a;
    lfsr[i*23 +: 23] = l;
    pw[i*12 +: 12] = p;
    ctrl[i*5 +: 5] = c;
    vol[i*8 +: 8] = v;
  endtask

  // Issue one frame, scramble inputs after accept, check latency and the
  // post-handshake state when the consumer is ready.
  task automatic run_frame(input string nm, input int exp_ns, input int exp_sat);
    int cyc;
    logic [11:0] e;
    e = SAT ? 12'(exp_sat) : 12'(exp_ns);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_q.push_back(e);
    acc = ~acc; lfsr = ~lfsr; pw = ~pw; ctrl = ~ctrl; vol = ~vol;
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
    end while (!mix_valid && cyc < 20);
    check({nm, " latency"}, cyc, 6);
    if (mix_ready) begin
      @(posedge clk); #1;
      check({nm, " valid drop"}, int'(mix_valid), 0);
      check({nm, " start_ready"}, int'(start_ready), 1);
      check({nm, " mix kept"}, int'(mix), int'(e));
    end
    clear_inputs();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; mix_ready = 1'b1;
    clear_inputs();
    // T1 reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset mix", int'(mix), 0);
    check("reset mix_valid", int'(mix_valid), 0);
    check("reset start_ready", int'(start_ready), 1);
    run_frame("T1 silent", 0, 0);

    // T2 saw
    set_voice(0, 24'h800000, '0, '0, 5'b00100, 8'hFF);
    run_frame("T2 saw", 510, 2040);
    // T3 pulse
    set_voice(0, 24'h7FF000, '0, 12'h800, 5'b00010, 8'h80);
    run_frame("T3 pulse below", 511, 2047);
    set_voice(0, 24'h800000, '0, 12'h800, 5'b00010, 8'h80);
    run_frame("T3 pulse at", 0, 0);
    // T4 ring
    set_voice(0, 24'h400000, '0, '0, 5'b11000, 8'hFF);
    set_voice(2, 24'h800000, '0, '0, 5'b00000, 8'h00);
    run_frame("T4 ring", 509, 2039);
    set_voice(0, 24'h400000, '0, '0, 5'b01000, 8'hFF);
    set_voice(2, 24'h800000, '0, '0, 5'b00000, 8'h00);
    run_frame("T4 no ring", 510, 2040);
    // T5 clip
    for (int i = 0; i < V; i++) set_voice(i, 24'hFFF000, '0, '0, 5'b00100, 8'hFF);
    run_frame("T5 clip", 3059, 4095);
    // Noise tap extraction
    set_voice(0, '0, 23'h144A25, '0, 5'b00001, 8'hFF);
    run_frame("noise", 1016, 4064);
    // Combined saw+pulse on one voice
    set_voice(0, 24'h7FF000, '0, 12'h800, 5'b00110, 8'hFF);
    run_frame("saw&pulse", 509, 2039);
    // Two active voices mixed
    set_voice(0, 24'h800000, '0, '0, 5'b00100, 8'hFF);
    set_voice(1, 24'h000000, '0, 12'h800, 5'b00010, 8'h80);
    run_frame("two voices", 1021, 4087);

    // T6 back-pressure: hold mix_ready low, start ignored
    set_voice(0, 24'h800000, '0, '0, 5'b00100, 8'hFF);
    mix_ready = 1'b0;
    run_frame("T6 hold", 510, 2040);
    for (int k = 0; k < 10; k++) begin
      start = (k < 5);
      set_voice(0, 24'hFFF000, '0, '0, 5'b00100, 8'hFF);
      @(posedge clk); #1;
      check($sformatf("T6 stable mix %0d", k), int'(mix), SAT ? 2040 : 510);
      check($sformatf("T6 valid %0d", k), int'(mix_valid), 1);
      check($sformatf("T6 start_ready %0d", k), int'(start_ready), 0);
    end
    start = 1'b0;
    mix_ready = 1'b1;
    @(posedge clk); #1;
    check("T6 release valid", int'(mix_valid), 0);
    check("T6 release idle", int'(start_ready), 1);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (mix_valid) seen++; end
    check("T6 start not queued", seen, 0);
    clear_inputs();

    // T6 reset mid-frame
    for (int i = 0; i < V; i++) set_voice(i, 24'hFFF000, '0, '0, 5'b00100, 8'hFF);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort mix", int'(mix), 0);
    check("abort start_ready", int'(start_ready), 1);
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (mix_valid) seen++; end
    check("abort no sample", seen, 0);
    clear_inputs();
    set_voice(0, 24'h800000, '0, '0, 5'b00100, 8'hFF);
    run_frame("after abort", 510, 2040);

    repeat (3) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
